// File: rtl/imem_loader_pkg.sv
// Shared definitions for the IMEM program loader: FSM state encoding and
// framing constants.
package imem_loader_pkg;

    localparam int LD_BYTES_PER_WORD = 4;
    localparam int LD_SUM_W          = 8;
    localparam int LD_IDX_W          = $clog2(LD_BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } ld_state_t;

endpackage

// File: rtl/ld_word_assembler.sv
// Collects host bytes MSB-first into a 32-bit word and keeps the running
// additive checksum of every byte accepted since the last clear.
module ld_word_assembler
    import imem_loader_pkg::*;
(
    input  logic                SYS_clk,
    input  logic                SYS_reset,
    input  logic                clear,
    input  logic                accept,
    input  logic [7:0]          byte_in,
    output logic                word_full,
    output logic [31:0]         word,
    output logic [LD_SUM_W-1:0] sum
);

    logic [LD_IDX_W-1:0] byte_idx;

    // High on the accept that completes the word, so the FSM can leave RECV on that edge.
    assign word_full = accept && (byte_idx == LD_IDX_W'(LD_BYTES_PER_WORD - 1));

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            byte_idx <= '0;
            word     <= '0;
            sum      <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word     <= '0;
            sum      <= '0;
        end else if (accept) begin
            byte_idx <= word_full ? '0 : byte_idx + LD_IDX_W'(1);
            word     <= {word[23:0], byte_in};
            sum      <= sum + LD_SUM_W'(byte_in);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a checksummed big-endian program frame from the host byte channel
// into IMEM while holding the CPU.
//
// state | meaning
// IDLE  | waiting for ld_start; CPU released
// RECV  | accepting data bytes of the current word
// WRITE | one-cycle IMEM write of the assembled word
// CHECK | accepting the checksum byte
// DONE  | one-cycle completion pulse
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 7
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [CNT_W-1:0]  ld_words,
    input  logic              ld_abort,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [31:0]       im_wr_data,
    output logic              cpu_hold,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_error
);

    ld_state_t             state;
    logic [ADDR_W-1:0]     addr;
    logic [CNT_W-1:0]      remaining;
    logic                  error_q;
    logic                  asm_clear;
    logic                  asm_accept;
    logic                  word_full;
    logic [31:0]           word;
    logic [LD_SUM_W-1:0]   sum;

    assign asm_clear  = (state == ST_IDLE) && ld_start;
    assign asm_accept = (state == ST_RECV) && ld_valid && !ld_abort;

    ld_word_assembler u_asm (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .clear     (asm_clear),
        .accept    (asm_accept),
        .byte_in   (ld_byte),
        .word_full (word_full),
        .word      (word),
        .sum       (sum)
    );

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            error_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld_start) begin
                        addr      <= ld_base & ~ADDR_W'(3);
                        remaining <= ld_words;
                        error_q   <= 1'b0;
                        state     <= (ld_words == '0) ? ST_CHECK : ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (ld_abort) begin
                        error_q <= 1'b1;
                        state   <= ST_DONE;
                    end else if (word_full) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (ld_abort) begin
                        error_q <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        addr      <= addr + ADDR_W'(LD_BYTES_PER_WORD);
                        remaining <= remaining - CNT_W'(1);
                        state     <= (remaining == CNT_W'(1)) ? ST_CHECK : ST_RECV;
                    end
                end
                ST_CHECK: begin
                    if (ld_abort) begin
                        error_q <= 1'b1;
                        state   <= ST_DONE;
                    end else if (ld_valid) begin
                        error_q <= (ld_byte != sum);
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ld_abort) error_q <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Abort must kill a write or handshake in the very cycle it arrives, so it gates the decode.
    assign ld_ready   = ((state == ST_RECV) || (state == ST_CHECK)) && !ld_abort;
    assign im_wr_en   = (state == ST_WRITE) && !ld_abort;
    assign im_wr_addr = addr;
    assign im_wr_data = word;
    assign cpu_hold   = (state != ST_IDLE);
    assign ld_busy    = (state != ST_IDLE);
    assign ld_done    = (state == ST_DONE);
    assign ld_error   = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of frames plus hand-written abort and
// reset/start-while-busy sequences.
module tb_imem_loader;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        ld_start, ld_abort, ld_valid;
    logic [7:0]  ld_base, ld_byte;
    logic [6:0]  ld_words;
    logic        ld_ready, im_wr_en, cpu_hold, ld_busy, ld_done, ld_error;
    logic [7:0]  im_wr_addr;
    logic [31:0] im_wr_data;

    int total = 0;
    int bad   = 0;

    logic [7:0]  aq[$];
    logic [31:0] dq[$];

    typedef struct packed {
        logic [7:0]       base;
        logic [6:0]       words;
        logic [2:0][31:0] w;
        logic [7:0]       csum;
        logic             gaps;
        logic             exp_err;
    } frame_t;

    frame_t tbl[6];
    logic   prev_err;

    imem_loader dut (
        .SYS_clk    (SYS_clk),
        .SYS_reset  (SYS_reset),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_words   (ld_words),
        .ld_abort   (ld_abort),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .im_wr_en   (im_wr_en),
        .im_wr_addr (im_wr_addr),
        .im_wr_data (im_wr_data),
        .cpu_hold   (cpu_hold),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .ld_error   (ld_error)
    );

    always #5 SYS_clk = ~SYS_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge SYS_clk) begin
        if (im_wr_en) begin
            aq.push_back(im_wr_addr);
            dq.push_back(im_wr_data);
            chk("ready_low_in_write", ld_ready, 0);
        end
    end

    function automatic frame_t mk(input logic [7:0] base, input logic [6:0] words,
                                  input logic [31:0] w0, input logic [31:0] w1,
                                  input logic [31:0] w2, input logic [7:0] csum,
                                  input logic gaps, input logic exp_err);
        frame_t f;
        f.base = base; f.words = words;
        f.w[0] = w0; f.w[1] = w1; f.w[2] = w2;
        f.csum = csum; f.gaps = gaps; f.exp_err = exp_err;
        return f;
    endfunction

    task automatic tick();
        @(posedge SYS_clk);
        #1;
    endtask

    // Called #1 after a posedge; returns #1 after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input logic gaps);
        logic got;
        if (gaps) begin
            ld_valid = 1'b0;
            ld_byte  = 8'hEE;
            repeat ($urandom_range(0, 2)) tick();
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            got = ld_ready;
            tick();
        end
        chk("byte_accepted", got, 1);
    endtask

    task automatic start_frame(input logic [7:0] base, input logic [6:0] words);
        ld_base  = base;
        ld_words = words;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err);
        for (int n = 0; n < 20 && !ld_done; n++) tick();
        chk("done_seen", ld_done, 1);
        chk("done_error", ld_error, exp_err);
        tick();
        chk("done_one_cycle", ld_done, 0);
        chk("hold_released", cpu_hold, 0);
        chk("busy_released", ld_busy, 0);
    endtask

    task automatic check_writes(input logic [7:0] base, input int n, input logic [2:0][31:0] w);
        logic [7:0] ea;
        chk("write_count", aq.size(), n);
        for (int i = 0; i < n && i < aq.size(); i++) begin
            ea = (base & 8'hFC) + 8'(4 * i);
            chk("write_addr", aq[i], ea);
            chk("write_data", dq[i], w[i]);
        end
    endtask

    task automatic run_frame(input frame_t f);
        logic [31:0] wv;
        aq.delete();
        dq.delete();
        chk("error_before_start", ld_error, prev_err);
        start_frame(f.base, f.words);
        chk("hold_after_start", cpu_hold, 1);
        chk("error_cleared", ld_error, 0);
        for (int i = 0; i < f.words; i++) begin
            wv = f.w[i];
            for (int b = 3; b >= 0; b--) send_byte(wv[8*b +: 8], f.gaps);
        end
        send_byte(f.csum, f.gaps);
        ld_valid = 1'b0;
        wait_done(f.exp_err);
        check_writes(f.base, int'(f.words), f.w);
        prev_err = f.exp_err;
    endtask

    initial begin
        SYS_reset = 1'b1;
        ld_start = 0; ld_abort = 0; ld_valid = 0;
        ld_base = 0; ld_words = 0; ld_byte = 0;
        prev_err = 1'b0;

        tbl[0] = mk(8'h10, 7'd2, 32'h20080005, 32'h0000000C, 32'h0, 8'h39, 1'b0, 1'b0);
        tbl[1] = mk(8'h10, 7'd2, 32'h20080005, 32'h0000000C, 32'h0, 8'h38, 1'b0, 1'b1);
        tbl[2] = mk(8'h10, 7'd2, 32'h20080005, 32'h0000000C, 32'h0, 8'h39, 1'b1, 1'b0);
        tbl[3] = mk(8'hFC, 7'd2, 32'h11223344, 32'hAABBCCDD, 32'h0, 8'hB8, 1'b1, 1'b0);
        tbl[4] = mk(8'h40, 7'd0, 32'h0,        32'h0,        32'h0, 8'h00, 1'b0, 1'b0);
        tbl[5] = mk(8'h23, 7'd1, 32'hDEADBEEF, 32'h0,        32'h0, 8'h38, 1'b0, 1'b0);

        repeat (3) tick();
        chk("rst_ready", ld_ready, 0);
        chk("rst_wr_en", im_wr_en, 0);
        chk("rst_addr", im_wr_addr, 0);
        chk("rst_data", im_wr_data, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_busy", ld_busy, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_error", ld_error, 0);
        SYS_reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i]);
            repeat (2) tick();
        end

        // Abort after 6 bytes of a 3-word frame, with a byte offered in the abort cycle.
        aq.delete();
        dq.delete();
        start_frame(8'h80, 7'd3);
        for (int b = 0; b < 6; b++) send_byte(8'h51 + 8'(b), 1'b0);
        ld_valid = 1'b1;
        ld_byte  = 8'h77;
        ld_abort = 1'b1;
        #1;
        chk("abort_ready_low", ld_ready, 0);
        tick();
        ld_abort = 1'b0;
        ld_valid = 1'b0;
        chk("abort_done", ld_done, 1);
        chk("abort_error", ld_error, 1);
        tick();
        chk("abort_idle", ld_busy, 0);
        chk("abort_write_count", aq.size(), 1);
        if (aq.size() > 0) begin
            chk("abort_write_addr", aq[0], 8'h80);
            chk("abort_write_data", dq[0], 32'h51525354);
        end
        ld_abort = 1'b1;
        tick();
        ld_abort = 1'b0;
        chk("idle_abort_busy", ld_busy, 0);
        chk("idle_abort_done", ld_done, 0);
        chk("idle_abort_error", ld_error, 1);
        prev_err = 1'b1;
        run_frame(tbl[0]);
        tick();

        // Start while busy, then reset mid-word.
        aq.delete();
        dq.delete();
        start_frame(8'h30, 7'd2);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        ld_valid = 1'b0;
        start_frame(8'h90, 7'd1);
        chk("busy_start_busy", ld_busy, 1);
        chk("busy_start_error", ld_error, 0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        ld_valid = 1'b0;
        chk("busy_write_count", aq.size(), 1);
        if (aq.size() > 0) begin
            chk("busy_write_addr", aq[0], 8'h30);
            chk("busy_write_data", dq[0], 32'hA1A2A3A4);
        end
        #1;
        SYS_reset = 1'b1;
        #1;
        chk("async_rst_ready", ld_ready, 0);
        chk("async_rst_wr_en", im_wr_en, 0);
        chk("async_rst_addr", im_wr_addr, 0);
        chk("async_rst_data", im_wr_data, 0);
        chk("async_rst_hold", cpu_hold, 0);
        chk("async_rst_busy", ld_busy, 0);
        chk("async_rst_done", ld_done, 0);
        chk("async_rst_error", ld_error, 0);
        tick();
        SYS_reset = 1'b0;
        tick();
        prev_err = 1'b0;
        run_frame(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
